// File: rtl/squash_pkg.sv
// Shared state, serve and direction encodings for the squash match controller.
package squash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_RALLY,
    ST_POINT,
    ST_DONE
  } state_t;

  localparam logic [1:0] SERVE_RALLY = 2'b00;
  localparam logic [1:0] SERVE_RIGHT = 2'b01;
  localparam logic [1:0] SERVE_LEFT  = 2'b10;

  localparam logic [1:0] DIR_IDLE     = 2'b00;
  localparam logic [1:0] DIR_TO_RIGHT = 2'b01;
  localparam logic [1:0] DIR_TO_LEFT  = 2'b10;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

  // server: 0 = right, 1 = left
  function automatic logic [1:0] serve_code(input logic server);
    return server ? SERVE_LEFT : SERVE_RIGHT;
  endfunction

endpackage

// File: rtl/squash_match_ctrl_if.sv
// Ball engine link: position/direction from the engine, serve command back to it.
interface squash_match_ctrl_if;
  logic [15:0] ball_pos;
  logic [1:0]  ball_dir;
  logic [1:0]  serve;

  modport master (
    output serve,
    input  ball_pos,
    input  ball_dir
  );

  modport slave (
    input  serve,
    output ball_pos,
    output ball_dir
  );
endinterface

// File: rtl/squash_swing_detect.sv
// Per-player button edge detector with a saturating early-swing counter.
module squash_swing_detect #(
  parameter int PEN_LIMIT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn,
  input  logic       pen_inc,
  input  logic       pen_clr,
  output logic       swing,
  output logic [1:0] pen,
  output logic       pen_at_limit
);

  localparam logic [2:0] PEN_LIMIT_L = 3'(PEN_LIMIT);

  logic       btn_q, btn_d;
  logic       swing_q, swing_d;
  logic [1:0] pen_q, pen_d;

  always_comb begin
    btn_d   = btn;
    swing_d = btn & ~btn_q;
    pen_d   = pen_q;
    if (pen_clr) begin
      pen_d = 2'd0;
    end else if (pen_inc && (pen_q != 2'b11)) begin
      pen_d = pen_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_q   <= 1'b0;
      swing_q <= 1'b0;
      pen_q   <= 2'd0;
    end else begin
      btn_q   <= btn_d;
      swing_q <= swing_d;
      pen_q   <= pen_d;
    end
  end

  // High when one more early swing would forfeit the point.
  assign pen_at_limit = ({1'b0, pen_q} + 3'd1) >= PEN_LIMIT_L;
  assign swing        = swing_q;
  assign pen          = pen_q;

endmodule

// File: rtl/squash_match_ctrl.sv
// Match controller: serve sequencing, hit/miss/early-swing detection, scoring.
// Define SQUASH_MATCH_WIN_BY_TWO_EN to require a two-point winning margin.
module squash_match_ctrl
  import squash_pkg::*;
#(
  parameter int WIN_SCORE  = 7,
  parameter int HIT_WINDOW = 4,
  parameter int PEN_LIMIT  = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       left_btn,
  input  logic                       right_btn,
  squash_match_ctrl_if.master        ball,
  output logic [3:0]                 right_score,
  output logic [3:0]                 left_score,
  output logic [1:0]                 right_pen,
  output logic [1:0]                 left_pen,
  output logic                       in_game,
  output logic                       match_over,
  output logic                       winner
);

  localparam logic [3:0] WIN_SCORE_L  = 4'(WIN_SCORE);
  localparam logic [7:0] HIT_WINDOW_L = 8'(HIT_WINDOW);

  state_t     state_q, state_d;
  logic       server_q, server_d;
  logic       pt_win_q, pt_win_d;
  logic       winner_q, winner_d;
  logic [3:0] right_score_q, right_score_d;
  logic [3:0] left_score_q, left_score_d;
  logic [7:0] win_cnt_q, win_cnt_d;
  logic       win_side_q, win_side_d;
  logic [1:0] serve_q, serve_d;
  logic       in_game_q, in_game_d;
  logic       match_over_q, match_over_d;

  logic right_swing, left_swing;
  logic right_at_limit, left_at_limit;
  logic pen_clr;

  logic       qual_right, qual_left, qual_any, recv_swing;
  logic       miss, early_right, early_left;
  logic [7:0] win_next;

  logic [3:0] new_right, new_left, win_score;
  logic       match_won;
`ifdef SQUASH_MATCH_WIN_BY_TWO_EN
  logic [3:0] lose_score;
`endif

  squash_swing_detect #(.PEN_LIMIT(PEN_LIMIT)) u_right_swing (
    .clock       (clock),
    .reset       (reset),
    .btn         (right_btn),
    .pen_inc     (early_right),
    .pen_clr     (pen_clr),
    .swing       (right_swing),
    .pen         (right_pen),
    .pen_at_limit(right_at_limit)
  );

  squash_swing_detect #(.PEN_LIMIT(PEN_LIMIT)) u_left_swing (
    .clock       (clock),
    .reset       (reset),
    .btn         (left_btn),
    .pen_inc     (early_left),
    .pen_clr     (pen_clr),
    .swing       (left_swing),
    .pen         (left_pen),
    .pen_at_limit(left_at_limit)
  );

  // The window counter only continues while the ball sits in the same end cell.
  always_comb begin
    qual_right = ball.ball_pos[0]  && (ball.ball_dir == DIR_TO_RIGHT);
    qual_left  = ball.ball_pos[15] && (ball.ball_dir == DIR_TO_LEFT);
    qual_any   = qual_right | qual_left;
    recv_swing = (qual_right & right_swing) | (qual_left & left_swing);
    win_next   = 8'd1;
    if ((win_cnt_q != 8'd0) && (qual_left == win_side_q)) begin
      win_next = win_cnt_q + 8'd1;
    end
    miss        = (state_q == ST_RALLY) && qual_any && !recv_swing &&
                  (win_next >= HIT_WINDOW_L);
    early_right = (state_q == ST_RALLY) && (ball.ball_dir == DIR_TO_RIGHT) &&
                  !ball.ball_pos[0] && right_swing;
    early_left  = (state_q == ST_RALLY) && (ball.ball_dir == DIR_TO_LEFT) &&
                  !ball.ball_pos[15] && left_swing;
  end

  always_comb begin
    new_right = pt_win_q ? right_score_q : sat_inc4(right_score_q);
    new_left  = pt_win_q ? sat_inc4(left_score_q) : left_score_q;
    win_score = pt_win_q ? new_left : new_right;
`ifdef SQUASH_MATCH_WIN_BY_TWO_EN
    lose_score = pt_win_q ? new_right : new_left;
    // A saturated score can no longer build a margin, so the leader takes it.
    match_won  = ((win_score >= WIN_SCORE_L) &&
                  ({1'b0, win_score} >= ({1'b0, lose_score} + 5'd2))) ||
                 ((win_score == 4'hF) && (win_score > lose_score));
`else
    match_won  = win_score >= WIN_SCORE_L;
`endif
  end

  always_comb begin
    state_d       = state_q;
    server_d      = server_q;
    pt_win_d      = pt_win_q;
    winner_d      = winner_q;
    right_score_d = right_score_q;
    left_score_d  = left_score_q;
    win_cnt_d     = 8'd0;
    win_side_d    = win_side_q;
    pen_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (right_swing || left_swing) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (server_q ? left_swing : right_swing) state_d = ST_RALLY;
      end
      ST_RALLY: begin
        if (qual_any && !recv_swing) begin
          win_cnt_d  = win_next;
          win_side_d = qual_left;
        end
        if (miss) begin
          pt_win_d = ~qual_left;
          state_d  = ST_POINT;
        end else if (early_right && right_at_limit) begin
          pt_win_d = 1'b1;
          state_d  = ST_POINT;
        end else if (early_left && left_at_limit) begin
          pt_win_d = 1'b0;
          state_d  = ST_POINT;
        end
      end
      ST_POINT: begin
        pen_clr       = 1'b1;
        right_score_d = new_right;
        left_score_d  = new_left;
        server_d      = pt_win_q;
        if (match_won) begin
          winner_d = pt_win_q;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_SERVE;
        end
      end
      ST_DONE: begin
        if (right_swing || left_swing) begin
          right_score_d = 4'd0;
          left_score_d  = 4'd0;
          server_d      = ~winner_q;
          state_d       = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    serve_d      = (state_d == ST_SERVE) ? serve_code(server_d) : SERVE_RALLY;
    in_game_d    = (state_d == ST_SERVE) || (state_d == ST_RALLY) ||
                   (state_d == ST_POINT);
    match_over_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      server_q      <= 1'b0;
      pt_win_q      <= 1'b0;
      winner_q      <= 1'b0;
      right_score_q <= 4'd0;
      left_score_q  <= 4'd0;
      win_cnt_q     <= 8'd0;
      win_side_q    <= 1'b0;
      serve_q       <= SERVE_RALLY;
      in_game_q     <= 1'b0;
      match_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      server_q      <= server_d;
      pt_win_q      <= pt_win_d;
      winner_q      <= winner_d;
      right_score_q <= right_score_d;
      left_score_q  <= left_score_d;
      win_cnt_q     <= win_cnt_d;
      win_side_q    <= win_side_d;
      serve_q       <= serve_d;
      in_game_q     <= in_game_d;
      match_over_q  <= match_over_d;
    end
  end

  assign ball.serve  = serve_q;
  assign right_score = right_score_q;
  assign left_score  = left_score_q;
  assign in_game     = in_game_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;

endmodule

// File: doc/squash_match_ctrl.md
# squash_match_ctrl

Match-level controller for the two-player squash/tennis game. It sequences serves, detects hits, misses and early-swing penalties from the ball engine's position and direction, keeps both players' scores, and decides the match winner. It sits between the two player buttons and the ball engine, driving the engine's `serve` input and the score/status outputs.

## Interface

Parameters:
- `WIN_SCORE`, default 7: points needed to win the match.
- `HIT_WINDOW`, default 4: cycles the ball may sit at an end position before the point counts as a miss.
- `PEN_LIMIT`, default 3: early swings that forfeit a point.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `left_btn`  in  1  left player button, level, already synchronised.
- `right_btn`  in  1  right player button, level, already synchronised.
- `ball_pos`  in  16  one-hot ball position from the ball engine; bit 0 is the right end, bit 15 is the left end.
- `ball_dir`  in  2  ball direction from the ball engine: 00 idle, 01 toward bit 0, 10 toward bit 15.
- `serve`  out  2  command to the ball engine: 00 rally, 01 right serves, 10 left serves.
- `right_score`, `left_score`  out  4 each  points.
- `right_pen`, `left_pen`  out  2 each  early-swing count in the current point.
- `in_game`  out  1  high from the first serve until the match ends.
- `match_over`  out  1  match finished.
- `winner`  out  1  0 = right, 1 = left; valid only while `match_over` is high.

## Operation

- **Button edges:** each button is registered internally. Only a rising edge (`btn & ~btn_q`) counts as a swing.
- **States:**
  - IDLE: after reset.
  - SERVE: `server` register selects 01 or 10 on `serve`.
  - RALLY: `serve` = 00.
  - POINT: one cycle; updates score and server.
  - DONE.
- **IDLE → SERVE:** on any swing. The initial server is right. `in_game` goes to 1.
- **SERVE → RALLY:** on a swing by the current server. Swings by the non-server in SERVE are ignored.
- **Hit (RALLY):** the ball is in the receiver's end cell (`ball_pos[0]` with dir 01 for right; `ball_pos[15]` with dir 10 for left) and the receiver swings. No score change. The window counter clears.
- **Miss (RALLY):** the ball stays in the receiver's end cell, with the direction unchanged, for `HIT_WINDOW` consecutive cycles without a receiver swing. The opponent wins the point → POINT.
- **Early swing (RALLY):** the ball is heading toward the player but is not in that player's end cell, and the player swings. That player's penalty count increments.
  - On reaching `PEN_LIMIT`, the opponent wins the point → POINT.
  - Counts saturate and never wrap.
- **Other swings** (ball heading away from the player, or `ball_dir` = 00) are ignored.
- **POINT:**
  - The winner's score increments and the winner becomes `server`.
  - Both penalty counts clear.
  - Then → DONE if the win condition holds, else → SERVE.
- **DONE:**
  - `match_over` = 1, `in_game` = 0, `winner` is held, and `serve` = 00.
  - A swing by either player clears both scores, sets `server` to the loser, and → SERVE.
- **Simultaneous events:** if both players qualify for a point in the same cycle, the miss takes priority over the penalty. Per-player penalty increments in one cycle are independent.
- **Arithmetic:** scores are 4-bit and saturate at 15. The win check uses `>= WIN_SCORE`.

## Timing

- **Reset values:**
  - `serve` = 00.
  - All scores and penalty counts = 0.
  - `in_game` = 0, `match_over` = 0, `winner` = 0.
  - State = IDLE, `server` = right, window counter = 0.
- **Reset mid-operation** returns to these values immediately (asynchronous).
- **Outputs are registered.**
  - A button rise sampled at edge N is detected at edge N+1.
  - `serve` changes at edge N+1.
  - A score update lands at edge N+2 (via POINT).
- **Miss timing:** a miss is declared on the `HIT_WINDOW`-th consecutive qualifying cycle. A swing on that same cycle counts as a hit.
- **POINT** lasts exactly one cycle. `serve` reads 01/10 on the next cycle.

## Configuration

- **`SQUASH_MATCH_WIN_BY_TWO_EN` defined:**
  - The win condition is winner score `>= WIN_SCORE` and a lead of at least 2.
  - If a score hits 15 without a 2-point lead, the leader wins.
- **Undefined:** the first player to reach `WIN_SCORE` wins.

## Structure

- **Shared package `squash_pkg`:**
  - State enum (`ST_IDLE`, `ST_SERVE`, `ST_RALLY`, `ST_POINT`, `ST_DONE`).
  - Serve encodings (`SERVE_RALLY` = 2'b00, `SERVE_RIGHT` = 2'b01, `SERVE_LEFT` = 2'b10).
  - Direction encodings (`DIR_IDLE`, `DIR_TO_RIGHT`, `DIR_TO_LEFT`).
- **Sub-module `squash_swing_detect`:** one instance per player. It registers the button, produces the swing pulse, and holds the saturating penalty counter with clear.

## Test plan

- Reset, right swing, ball engine returns dir 01 toward bit 0, right swing at `ball_pos` = 0x0001 → no score; `serve` goes 01 then 00.
- Ball held at 0x0001 with dir 01 for 4 cycles with no right swing → `left_score` = 1, `serve` = 10 one cycle after POINT.
- Right swings 3 times while ball is at 0x0100 with dir 01 → `right_pen` 1, 2, then `left_score` +1 and `right_pen` = 0.
- Left reaches 7 with right at 3 → `match_over` = 1, `winner` = 1, `in_game` = 0; next swing → scores 0, `serve` = 01.
- With `SQUASH_MATCH_WIN_BY_TWO_EN`, 7–6 → play continues; 8–6 → `match_over`.
- Reset asserted during RALLY with score 3–2 → all outputs return to reset values in the same cycle.
